// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem bvudiv/bvuge sweep checker: FSM states,
// default operand width and the result-counter width.
package skolem_chk_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StDiv,
        StCheck,
        StDone
    } state_e;

    // Counters must hold 2^(2W) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// W-cycle restoring unsigned divider. Loads on go, produces one quotient bit
// per cycle; a zero divisor naturally yields an all-ones quotient.
module udiv_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quot,
    output logic         rdy
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] Steps = CntW'(W);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    dvs_q;
    logic [CntW-1:0] cnt_q;
    logic            rdy_q;
    logic [W:0]      partial;
    logic [W:0]      diff;
    logic            fits;

    // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
    assign partial = {rem_q, quo_q[W-1]};
    assign diff    = partial - {1'b0, dvs_q};
    assign fits    = partial >= {1'b0, dvs_q};
    assign quot    = quo_q;
    assign rdy     = rdy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else if (go) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= Steps;
            rdy_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q <= fits ? diff[W-1:0] : partial[W-1:0];
            quo_q <= {quo_q[W-2:0], fits};
            cnt_q <= cnt_q - CntOne;
            if (cnt_q == CntOne) begin
                rdy_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/skolem_udiv_sweep_checker.sv
// Exhaustive checker for a combinational bvuge/bvudiv Skolem block: sweeps all
// (s, t) pairs, divides the witness and all-ones by s, and classifies each pair.
module skolem_udiv_sweep_checker
    import skolem_chk_pkg::*;
#(
    parameter int unsigned W = DefaultWidth,
    localparam int unsigned CntW = cnt_width(W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [W-1:0]    sk_s,
    output logic [W-1:0]    sk_t,
    input  logic [W-1:0]    sk_x,
    output logic            busy,
    output logic            done,
    output logic [CntW-1:0] pass_cnt,
    output logic [CntW-1:0] fail_cnt,
    output logic [CntW-1:0] vac_cnt,
    output logic [CntW-1:0] icmm_cnt,
    output logic            fail_valid,
    output logic [W-1:0]    fail_s,
    output logic [W-1:0]    fail_t,
    output logic [W-1:0]    fail_x
);

    localparam int unsigned DcW = $clog2(W + 1);
    localparam logic [DcW-1:0]   DivLast = DcW'(W - 1);
    localparam logic [DcW-1:0]   DcOne   = DcW'(1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);
    localparam logic [2*W-1:0]   PairOne = (2 * W)'(1);

    state_e         state_q;
    logic [DcW-1:0] div_cnt_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   q1;
    logic [W-1:0]   q2;
    logic           rdy1;
    logic           rdy2;
    logic           go;
    logic           pred;
    logic           ic;
    logic           last_pair;

    assign go        = state_q == StDrive;
    assign pred      = q1 >= sk_t;
    assign ic        = q2 >= sk_t;
    assign last_pair = &{sk_s, sk_t};

    // The x divider loads sk_x directly in DRIVE, the same edge that captures x_q.
    udiv_seq #(.W(W)) u_div_x (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .dividend (sk_x),
        .divisor  (sk_s),
        .quot     (q1),
        .rdy      (rdy1)
    );

    udiv_seq #(.W(W)) u_div_ic (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .dividend ({W{1'b1}}),
        .divisor  (sk_s),
        .quot     (q2),
        .rdy      (rdy2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            x_q        <= '0;
            sk_s       <= '0;
            sk_t       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            vac_cnt    <= '0;
            icmm_cnt   <= '0;
            fail_valid <= 1'b0;
            fail_s     <= '0;
            fail_t     <= '0;
            fail_x     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        vac_cnt    <= '0;
                        icmm_cnt   <= '0;
                        fail_valid <= 1'b0;
                        fail_s     <= '0;
                        fail_t     <= '0;
                        fail_x     <= '0;
                        sk_s       <= '0;
                        sk_t       <= '0;
                        busy       <= 1'b1;
                        state_q    <= StDrive;
                    end
                end
                StDrive: begin
                    x_q       <= sk_x;
                    div_cnt_q <= '0;
                    state_q   <= StDiv;
                end
                StDiv: begin
                    if (div_cnt_q == DivLast) begin
                        state_q <= StCheck;
                    end else begin
                        div_cnt_q <= div_cnt_q + DcOne;
                    end
                end
                StCheck: begin
                    if (rdy1 && rdy2) begin
                        case ({ic, pred})
                            2'b11:   pass_cnt <= pass_cnt + CntOne;
                            2'b10:   fail_cnt <= fail_cnt + CntOne;
                            2'b01:   icmm_cnt <= icmm_cnt + CntOne;
                            default: vac_cnt  <= vac_cnt + CntOne;
                        endcase
                        if (ic && !pred && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_s     <= sk_s;
                            fail_t     <= sk_t;
                            fail_x     <= x_q;
                        end
                        // done/busy are set here so they appear in the DONE cycle.
                        if (last_pair) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            {sk_s, sk_t} <= {sk_s, sk_t} + PairOne;
                            state_q      <= StDrive;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_udiv_sweep_checker.sv
// Randomized bench: plays several Skolem models against the checker and compares
// its counters and first-fail capture with a direct arithmetic sweep.
module tb_skolem_udiv_sweep_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] sk_s;
    logic [W-1:0] sk_t;
    logic [W-1:0] sk_x;
    logic         busy;
    logic         done;
    logic [2*W:0] pass_cnt;
    logic [2*W:0] fail_cnt;
    logic [2*W:0] vac_cnt;
    logic [2*W:0] icmm_cnt;
    logic         fail_valid;
    logic [W-1:0] fail_s;
    logic [W-1:0] fail_t;
    logic [W-1:0] fail_x;

    int           mode;
    logic [W-1:0] xtab [256];
    int           n_checks = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    skolem_udiv_sweep_checker #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sk_s       (sk_s),
        .sk_t       (sk_t),
        .sk_x       (sk_x),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .vac_cnt    (vac_cnt),
        .icmm_cnt   (icmm_cnt),
        .fail_valid (fail_valid),
        .fail_s     (fail_s),
        .fail_t     (fail_t),
        .fail_x     (fail_x)
    );

    // Skolem block under test: 0 ideal, 1 stuck-at-zero, 2 x = t, else random table.
    always_comb begin
        sk_x = '0;
        case (mode)
            0:       sk_x = 4'hF;
            1:       sk_x = 4'h0;
            2:       sk_x = sk_t;
            default: sk_x = xtab[{sk_s, sk_t}];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int model_x(input int s, input int t);
        case (mode)
            0:       return 15;
            1:       return 0;
            2:       return t;
            default: return int'(xtab[s * 16 + t]);
        endcase
    endfunction

    function automatic int udiv(input int a, input int b);
        return (b == 0) ? 15 : a / b;
    endfunction

    task automatic check_results(input string tag, input int done_cyc);
        int e_pass = 0, e_fail = 0, e_vac = 0, e_icmm = 0;
        int e_fv = 0, e_fs = 0, e_ft = 0, e_fx = 0;
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 16; t++) begin
                int  x = model_x(s, t);
                bit  pr = udiv(x, s) >= t;
                bit  icv = udiv(15, s) >= t;
                if (icv && pr) e_pass++;
                else if (icv) begin
                    e_fail++;
                    if (e_fv == 0) begin
                        e_fv = 1; e_fs = s; e_ft = t; e_fx = x;
                    end
                end else if (pr) e_icmm++;
                else e_vac++;
            end
        end
        check({tag, "_done_cycle"}, done_cyc, 1537);
        check({tag, "_pass"}, pass_cnt, e_pass);
        check({tag, "_fail"}, fail_cnt, e_fail);
        check({tag, "_vac"}, vac_cnt, e_vac);
        check({tag, "_icmm"}, icmm_cnt, e_icmm);
        check({tag, "_sum"}, pass_cnt + fail_cnt + vac_cnt + icmm_cnt, 256);
        check({tag, "_fail_valid"}, fail_valid, e_fv);
        check({tag, "_fail_s"}, fail_s, e_fs);
        check({tag, "_fail_t"}, fail_t, e_ft);
        check({tag, "_fail_x"}, fail_x, e_fx);
    endtask

    // Cycle 0 is the cycle in which start is high; returns the cycle done was seen.
    task automatic run_sweep(input string tag, input int restart_at, output int done_cyc);
        int cyc = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 3000 && done_cyc < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) check({tag, "_busy_at_1"}, busy, 1);
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_len"}, done, 0);
    endtask

    initial begin
        int dc;
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_counts", pass_cnt | fail_cnt | vac_cnt | icmm_cnt, 0);
        check("rst_fail", {fail_valid, fail_s, fail_t, fail_x}, 0);
        check("rst_operands", {sk_s, sk_t}, 0);
        rst = 1'b0;

        mode = 0; run_sweep("ideal", -1, dc); check_results("ideal", dc);
        mode = 1; run_sweep("zero", -1, dc); check_results("zero", dc);
        mode = 2; run_sweep("x_eq_t", -1, dc); check_results("x_eq_t", dc);

        for (int r = 0; r < 2; r++) begin
            mode = 3;
            for (int i = 0; i < 256; i++) xtab[i] = 4'($urandom_range(0, 15));
            run_sweep("random", -1, dc);
            check_results("random", dc);
        end

        mode = 2; run_sweep("restart", 100, dc); check_results("restart", dc);

        // Reset in the middle of a random-model sweep.
        mode = 3;
        for (int i = 0; i < 256; i++) xtab[i] = 4'($urandom_range(0, 15));
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_counts", pass_cnt | fail_cnt | vac_cnt | icmm_cnt, 0);
        check("midrst_fail", {fail_valid, fail_s, fail_t, fail_x}, 0);
        check("midrst_operands", {sk_s, sk_t}, 0);
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            done_seen |= int'(done | busy);
        end
        check("midrst_idle_after", done_seen, 0);
        run_sweep("after_rst", -1, dc);
        check_results("after_rst", dc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
